// File: rtl/dht11_pkg.sv
// Shared DHT11 protocol definitions: responder FSM states, timing defaults,
// frame layout and the frame checksum helper.
package dht11_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_LOW,
    S_RESP_DELAY,
    S_ACK_LOW,
    S_ACK_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } dht11_state_t;

  localparam int HOST_START_LOW_US        = 18000;
  localparam int START_LOW_MIN_US_DEFAULT = 16000;
  localparam int RESP_DELAY_US_DEFAULT    = 30;
  localparam int ACK_US_DEFAULT           = 80;
  localparam int BIT_LOW_US_DEFAULT       = 50;
  localparam int ZERO_HIGH_US_DEFAULT     = 26;
  localparam int ONE_HIGH_US_DEFAULT      = 70;
  localparam int FRAME_BITS               = 40;

  // Checksum is the plain 8-bit wrapping sum of the four data bytes.
  function automatic logic [7:0] frameChecksum(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2, input logic [7:0] b3);
    return b0 + b1 + b2 + b3;
  endfunction

  function automatic logic [15:0] lastCount(input int us);
    return 16'(us - 1);
  endfunction

endpackage

// File: rtl/dht11_bus_sync.sv
// Two-flop synchronizer for a DHT11 data line with registered rise/fall pulses.
// The line idles high (pulled up), so the flops reset to 1.
module dht11_bus_sync (
  input  logic clk1Mhz,
  input  logic reset,
  input  logic i_data,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk1Mhz or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_data;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side emulator: answers a host start pulse with the ack and a 40-bit frame.
// Optional DHT11_RESP_FAULT_INJ_EN adds fault_checksum to corrupt the transmitted checksum.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int START_LOW_MIN_US = START_LOW_MIN_US_DEFAULT,
  parameter int RESP_DELAY_US    = RESP_DELAY_US_DEFAULT,
  parameter int ACK_US           = ACK_US_DEFAULT,
  parameter int BIT_LOW_US       = BIT_LOW_US_DEFAULT,
  parameter int ZERO_HIGH_US     = ZERO_HIGH_US_DEFAULT,
  parameter int ONE_HIGH_US      = ONE_HIGH_US_DEFAULT
) (
  input  logic       clk1Mhz,
  input  logic       reset,
  inout  wire        dht11_data,
  input  logic [7:0] humidity_int,
  input  logic [7:0] humidity_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       frame_done,
  output logic [5:0] bit_index
`ifdef DHT11_RESP_FAULT_INJ_EN
  ,
  input  logic       fault_checksum
`endif
);

  localparam logic [15:0] C_START_MIN   = 16'(START_LOW_MIN_US);
  localparam logic [15:0] C_RESP_LAST   = lastCount(RESP_DELAY_US);
  localparam logic [15:0] C_ACK_LAST    = lastCount(ACK_US);
  localparam logic [15:0] C_BITLOW_LAST = lastCount(BIT_LOW_US);
  localparam logic [15:0] C_ZERO_LAST   = lastCount(ZERO_HIGH_US);
  localparam logic [15:0] C_ONE_LAST    = lastCount(ONE_HIGH_US);
  localparam logic [5:0]  C_LAST_BIT    = 6'(FRAME_BITS - 1);

  dht11_state_t r_state;
  logic [15:0]  r_count;
  logic [39:0]  r_shift;
  logic [5:0]   r_bitIndex;
  logic         r_driveLow;
  logic         r_busy;
  logic         r_frameDone;

  logic         w_sync;
  logic         w_rise;
  logic         w_fall;
  logic [7:0]   w_checksum;
  logic [15:0]  w_highLast;

  dht11_bus_sync u_sync (
    .clk1Mhz (clk1Mhz),
    .reset   (reset),
    .i_data  (dht11_data),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

`ifdef DHT11_RESP_FAULT_INJ_EN
  assign w_checksum = frameChecksum(humidity_int, humidity_dec, temp_int, temp_dec)
                      ^ {7'd0, fault_checksum};
`else
  assign w_checksum = frameChecksum(humidity_int, humidity_dec, temp_int, temp_dec);
`endif

  assign w_highLast = r_shift[39] ? C_ONE_LAST : C_ZERO_LAST;

  // Every phase exits when the counter reaches N-1, so each phase lasts exactly N cycles.
  always_ff @(posedge clk1Mhz or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_shift     <= '0;
      r_bitIndex  <= '0;
      r_driveLow  <= 1'b0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (!w_sync) begin
            r_state <= S_HOST_LOW;
            r_count <= '0;
          end
        end
        S_HOST_LOW: begin
          if (w_rise) begin
            r_count <= '0;
            if (r_count >= C_START_MIN) begin
              r_state    <= S_RESP_DELAY;
              r_busy     <= 1'b1;
              r_bitIndex <= '0;
              r_shift    <= {humidity_int, humidity_dec, temp_int, temp_dec, w_checksum};
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_fall) begin
            // Rise and fall pulses share the same latency, so restarting here measures the true width.
            r_count <= '0;
          end
        end
        S_RESP_DELAY: begin
          if (r_count == C_RESP_LAST) begin
            r_state    <= S_ACK_LOW;
            r_count    <= '0;
            r_driveLow <= 1'b1;
          end
        end
        S_ACK_LOW: begin
          if (r_count == C_ACK_LAST) begin
            r_state    <= S_ACK_HIGH;
            r_count    <= '0;
            r_driveLow <= 1'b0;
          end
        end
        S_ACK_HIGH: begin
          if (r_count == C_ACK_LAST) begin
            r_state    <= S_BIT_LOW;
            r_count    <= '0;
            r_driveLow <= 1'b1;
          end
        end
        S_BIT_LOW: begin
          if (r_count == C_BITLOW_LAST) begin
            r_state    <= S_BIT_HIGH;
            r_count    <= '0;
            r_driveLow <= 1'b0;
          end
        end
        S_BIT_HIGH: begin
          if (r_count == w_highLast) begin
            r_state    <= (r_bitIndex == C_LAST_BIT) ? S_END_LOW : S_BIT_LOW;
            r_count    <= '0;
            r_shift    <= {r_shift[38:0], 1'b0};
            r_bitIndex <= r_bitIndex + 6'd1;
            r_driveLow <= 1'b1;
          end
        end
        S_END_LOW: begin
          if (r_count == C_BITLOW_LAST) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_driveLow  <= 1'b0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_count    <= '0;
          r_driveLow <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign dht11_data = r_driveLow ? 1'b0 : 1'bz;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;
  assign bit_index  = r_bitIndex;

endmodule
